// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl
//  Purpose  : Pipeline hazard controller. Detects load-use hazards, EX-stage
//             control-flow redirects and data-memory wait cycles, drives the
//             stall / flush / freeze controls for the pipeline, and keeps
//             saturating performance counters for each event class.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  input  logic        ex_redirect,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        cnt_clr,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        id_ex_stall,
  output logic        pipe_freeze,
  output logic [15:0] lu_cnt,
  output logic [15:0] flush_cnt,
  output logic [15:0] freeze_cnt,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LOAD_USE = 2'd1,
    MEM_WAIT = 2'd2,
    REDIRECT = 2'd3
  } state_t;

  localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

  state_t r_state;
  state_t w_next_state;
  logic   w_mw;
  logic   w_lu;

  // Memory wait: an access is outstanding and has not completed this cycle.
  assign w_mw = mem_req & ~mem_ready;

  // Load-use: the load in EX writes a register the ID instruction reads.
  // Register 0 is hardwired, so a load targeting it never creates a hazard.
  assign w_lu = ex_mem_read & (ex_rt != 5'd0) &
                ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

  assign state = r_state;

  // State register; asynchronous reset returns the controller to RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Mealy next-state and control outputs. A memory wait overrides everything;
  // a redirect beats a load-use because the flushed instruction needs no stall.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    pipe_freeze  = 1'b0;
    w_next_state = RUN;
    if (w_mw) begin
      pipe_freeze  = 1'b1;
      w_next_state = MEM_WAIT;
    end else begin
      case (r_state)
        RUN, MEM_WAIT: begin
          if (ex_redirect) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            w_next_state = REDIRECT;
          end else if (w_lu) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            w_next_state = LOAD_USE;
          end
        end
        LOAD_USE: begin
          // The inserted bubble already separates the load from its consumer.
          if (ex_redirect) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            w_next_state = REDIRECT;
          end
        end
        REDIRECT: begin
          // ID/EX holds a flushed bubble: its redirect/load flags are stale.
          w_next_state = RUN;
        end
        default: begin
          w_next_state = RUN;
        end
      endcase
    end
  end

  // Saturating event counters; clear takes priority over counting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lu_cnt     <= 16'd0;
      flush_cnt  <= 16'd0;
      freeze_cnt <= 16'd0;
    end else if (cnt_clr) begin
      lu_cnt     <= 16'd0;
      flush_cnt  <= 16'd0;
      freeze_cnt <= 16'd0;
    end else begin
      if (id_ex_stall && (lu_cnt != C_CNT_MAX)) begin
        lu_cnt <= lu_cnt + 16'd1;
      end
      if (id_ex_flush && (flush_cnt != C_CNT_MAX)) begin
        flush_cnt <= flush_cnt + 16'd1;
      end
      if (pipe_freeze && (freeze_cnt != C_CNT_MAX)) begin
        freeze_cnt <= freeze_cnt + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_ctrl
//  Purpose  : Self-checking bench for hazard_ctrl: table of single-cycle
//             vectors plus hand-written multi-cycle sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        ex_redirect;
  logic        mem_req;
  logic        mem_ready;
  logic        cnt_clr;
  logic        pc_stall;
  logic        if_id_stall;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        id_ex_stall;
  logic        pipe_freeze;
  logic [15:0] lu_cnt;
  logic [15:0] flush_cnt;
  logic [15:0] freeze_cnt;
  logic [1:0]  state;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_STL  = 6'b110010;
  localparam logic [5:0] C_FLS  = 6'b001100;
  localparam logic [5:0] C_FRZ  = 6'b000001;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urt;
    logic       mr;
    logic [4:0] ert;
    logic       red;
    logic       mreq;
    logic       mrdy;
    logic [5:0] exp_out;
    logic [1:0] st_now;
    logic [1:0] st_next;
  } vec_t;

  vec_t tv [20];

  hazard_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .ex_redirect (ex_redirect),
    .mem_req     (mem_req),
    .mem_ready   (mem_ready),
    .cnt_clr     (cnt_clr),
    .pc_stall    (pc_stall),
    .if_id_stall (if_id_stall),
    .if_id_flush (if_id_flush),
    .id_ex_flush (id_ex_flush),
    .id_ex_stall (id_ex_stall),
    .pipe_freeze (pipe_freeze),
    .lu_cnt      (lu_cnt),
    .flush_cnt   (flush_cnt),
    .freeze_cnt  (freeze_cnt),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {pc_stall, if_id_stall, if_id_flush, id_ex_flush, id_ex_stall, pipe_freeze};
  endfunction

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                       input logic mr, input logic [4:0] ert, input logic red,
                       input logic mreq, input logic mrdy);
    id_rs = rs; id_rt = rt; id_uses_rt = urt;
    ex_mem_read = mr; ex_rt = ert; ex_redirect = red;
    mem_req = mreq; mem_ready = mrdy;
  endtask

  initial begin
    //           rs    rt    urt   mr    ert   red   mreq  mrdy  out     now   next
    tv[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_NONE, 2'd0, 2'd0};
    tv[1]  = '{5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, C_STL,  2'd0, 2'd1};
    tv[2]  = '{5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, C_NONE, 2'd1, 2'd0};
    tv[3]  = '{5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, C_NONE, 2'd0, 2'd0};
    tv[4]  = '{5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, C_NONE, 2'd0, 2'd0};
    tv[5]  = '{5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, C_STL,  2'd0, 2'd1};
    tv[6]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, C_FLS,  2'd1, 2'd3};
    tv[7]  = '{5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, C_NONE, 2'd3, 2'd0};
    tv[8]  = '{5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, C_FLS,  2'd0, 2'd3};
    tv[9]  = '{5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, C_NONE, 2'd3, 2'd0};
    tv[10] = '{5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, C_FRZ,  2'd0, 2'd2};
    tv[11] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_FRZ,  2'd2, 2'd2};
    tv[12] = '{5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b1, C_STL,  2'd2, 2'd1};
    tv[13] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_FRZ,  2'd1, 2'd2};
    tv[14] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_NONE, 2'd2, 2'd0};
    tv[15] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, C_FLS,  2'd0, 2'd3};
    tv[16] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_FRZ,  2'd3, 2'd2};
    tv[17] = '{5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, C_STL,  2'd2, 2'd1};
    tv[18] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_NONE, 2'd1, 2'd0};
    tv[19] = '{5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, C_NONE, 2'd0, 2'd0};

    reset   = 1'b1;
    cnt_clr = 1'b0;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #2;
    chk("reset_state", {30'd0, state}, 32'd0);
    chk("reset_lu_cnt", {16'd0, lu_cnt}, 32'd0);
    chk("reset_outputs", {26'd0, outs()}, {26'd0, C_NONE});
    @(negedge clk);
    reset = 1'b0;

    // Table of single-cycle vectors
    for (int i = 0; i < 20; i++) begin
      drive(tv[i].rs, tv[i].rt, tv[i].urt, tv[i].mr, tv[i].ert, tv[i].red, tv[i].mreq, tv[i].mrdy);
      #1;
      chk($sformatf("vec%0d_out", i), {26'd0, outs()}, {26'd0, tv[i].exp_out});
      chk($sformatf("vec%0d_state", i), {30'd0, state}, {30'd0, tv[i].st_now});
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_next", i), {30'd0, state}, {30'd0, tv[i].st_next});
    end
    chk("table_lu_cnt", {16'd0, lu_cnt}, 32'd4);
    chk("table_flush_cnt", {16'd0, flush_cnt}, 32'd3);
    chk("table_freeze_cnt", {16'd0, freeze_cnt}, 32'd4);

    // Counter clear
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    chk("clr_lu_cnt", {16'd0, lu_cnt}, 32'd0);
    chk("clr_flush_cnt", {16'd0, flush_cnt}, 32'd0);
    chk("clr_freeze_cnt", {16'd0, freeze_cnt}, 32'd0);

    // Four wait cycles, then completion together with a redirect
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("mw%0d_out", c), {26'd0, outs()}, {26'd0, C_FRZ});
      @(posedge clk); #1;
      chk($sformatf("mw%0d_state", c), {30'd0, state}, 32'd2);
    end
    chk("mw_freeze_cnt", {16'd0, freeze_cnt}, 32'd4);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
    #1;
    chk("mw_done_out", {26'd0, outs()}, {26'd0, C_FLS});
    @(posedge clk); #1;
    chk("mw_done_state", {30'd0, state}, 32'd3);
    chk("mw_done_flush_cnt", {16'd0, flush_cnt}, 32'd1);
    chk("mw_done_freeze_cnt", {16'd0, freeze_cnt}, 32'd4);

    // Enter MEM_WAIT, then reset asynchronously between edges
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("pre_rst_state", {30'd0, state}, 32'd2);
    chk("pre_rst_freeze_cnt", {16'd0, freeze_cnt}, 32'd5);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_state", {30'd0, state}, 32'd0);
    chk("arst_freeze_cnt", {16'd0, freeze_cnt}, 32'd0);
    chk("arst_flush_cnt", {16'd0, flush_cnt}, 32'd0);
    chk("arst_outputs", {26'd0, outs()}, {26'd0, C_NONE});
    @(negedge clk);
    reset = 1'b0;

    // Detection is live in the first cycle after reset release
    drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    #1;
    chk("post_rst_out", {26'd0, outs()}, {26'd0, C_STL});
    @(posedge clk); #1;
    chk("post_rst_state", {30'd0, state}, 32'd1);
    chk("post_rst_lu_cnt", {16'd0, lu_cnt}, 32'd1);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Saturation: 70000 freeze cycles
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    repeat (70000) @(posedge clk);
    #1;
    chk("sat_freeze_cnt", {16'd0, freeze_cnt}, 32'h0000FFFF);
    chk("sat_state", {30'd0, state}, 32'd2);
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    chk("sat_clr_freeze_cnt", {16'd0, freeze_cnt}, 32'd0);
    cnt_clr = 1'b0;
    @(posedge clk); #1;
    chk("sat_recount", {16'd0, freeze_cnt}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset is asynchronous and active-high.
REQ-003 SHALL have ports id_rs and id_rt, input, 5 bits each: source register numbers of the instruction in ID.
REQ-004 SHALL have port id_uses_rt, input, 1 bit: the ID instruction reads rt as a source.
REQ-005 SHALL have ports ex_mem_read (input, 1 bit) and ex_rt (input, 5 bits): a load is in EX, and its destination register.
REQ-006 SHALL have port ex_redirect, input, 1 bit: a taken branch, j, jr or jal is resolved in EX.
REQ-007 SHALL have ports mem_req and mem_ready, input, 1 bit each: a data-memory access is in MEM, and that access completes this cycle.
REQ-008 SHALL have ports pc_stall and if_id_stall, output, 1 bit each: hold the PC and hold IF/ID.
REQ-009 SHALL have ports if_id_flush, id_ex_flush and id_ex_stall, output, 1 bit each: clear IF/ID, and insert a bubble into ID/EX.
REQ-010 SHALL have port pipe_freeze, output, 1 bit: global enable-low for every pipeline register, including EX/MEM and MEM/WB.
REQ-011 SHALL have port cnt_clr, input, 1 bit: synchronous clear of the counters.
REQ-012 SHALL have ports lu_cnt, flush_cnt and freeze_cnt, output, 16 bits each: performance counters.
REQ-013 SHALL have port state, output, 2 bits: current FSM state.

Function
REQ-014 SHALL use internal signals: mw = mem_req & ~mem_ready; lu = ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & ex_rt == id_rt)).
REQ-015 SHALL implement states RUN = 0, LOAD_USE = 1, MEM_WAIT = 2, REDIRECT = 3.
REQ-016 SHALL compute outputs combinationally from state and inputs (Mealy), so the response is in the same cycle with zero latency.
REQ-017 SHALL apply this priority in every state: mw, then ex_redirect, then lu.
REQ-018 SHALL, whenever mw = 1: assert pipe_freeze only, with all other control outputs 0; next state MEM_WAIT.
REQ-019 SHALL, in RUN or MEM_WAIT with mw = 0 and ex_redirect = 1: assert if_id_flush and id_ex_flush; next state REDIRECT.
REQ-020 SHALL, in RUN or MEM_WAIT with mw = 0, ex_redirect = 0 and lu = 1: assert pc_stall, if_id_stall and id_ex_stall; next state LOAD_USE.
REQ-021 SHALL, in RUN or MEM_WAIT with no condition true: drive all outputs 0; next state RUN.
REQ-022 SHALL ignore lu in LOAD_USE (the bubble already separates load and use); ex_redirect and mw are still honoured per REQ-018/019; otherwise next state RUN.
REQ-023 SHALL ignore both lu and ex_redirect in REDIRECT (ID/EX holds a flushed bubble); mw is still honoured; otherwise next state RUN.
REQ-024 SHALL keep pipe_freeze asserted for every cycle that mw = 1, with no upper bound.
REQ-025 SHALL, in the cycle mem_ready rises, deassert pipe_freeze and evaluate redirect/lu in that same cycle.
REQ-026 SHALL never assert a stall output and a flush output in the same cycle; pipe_freeze SHALL be exclusive with all other outputs.
REQ-027 SHALL increment lu_cnt on each cycle id_ex_stall = 1, flush_cnt on each cycle id_ex_flush = 1, and freeze_cnt on each cycle pipe_freeze = 1.
REQ-028 SHALL saturate each counter at 0xFFFF, with no wrap.
REQ-029 SHALL give cnt_clr priority over increment; a cleared counter reads 0 on the next cycle.
REQ-030 SHALL make the state register and counters the only storage in the block.

Reset
REQ-031 SHALL, while reset = 1: state = RUN and all counters = 0, immediately and independent of clk.
REQ-032 SHALL, with reset asserted mid-MEM_WAIT or mid-LOAD_USE, return to RUN; outputs then follow REQ-021 for the current inputs.
REQ-033 SHALL leave the first cycle after reset release in RUN with normal detection enabled.

Verification
REQ-034 Load-use: ex_mem_read = 1, ex_rt = 5, id_rs = 5, held for 2 cycles -> cycle 1: pc_stall = if_id_stall = id_ex_stall = 1, state goes to 1; cycle 2: outputs 0, state 0, lu_cnt = 1.
REQ-035 rt/r0 filter: ex_rt = 0 = id_rs -> no stall; ex_rt = 7 = id_rt with id_uses_rt = 0 -> no stall, and with id_uses_rt = 1 -> stall.
REQ-036 Redirect over load-use: ex_redirect = 1 together with an lu match -> both flushes = 1, no stall, state 3; next cycle with ex_redirect still 1 -> all outputs 0, flush_cnt = 1.
REQ-037 Memory wait: mem_req = 1, mem_ready = 0 for 4 cycles, then mem_ready = 1 with ex_redirect = 1 -> pipe_freeze for 4 cycles, freeze_cnt = 4, then flush in cycle 5, state 3.
REQ-038 Saturation and clear: force 70000 freeze cycles -> freeze_cnt = 0xFFFF; cnt_clr = 1 together with freeze -> 0.
REQ-039 Async reset: assert reset between clock edges in MEM_WAIT -> state = 0 and counters = 0 before the next edge.
